// File: rtl/kronos_issue_sched.sv
// Kronos ID->EX issue scheduler: scoreboard-gated valid/ready with in-flight write budget.
// Optional stall statistics counter enabled by defining KRONOS_ISSUE_STATS_EN.
module kronos_issue_sched #(
    parameter int MAX_INFLIGHT = 2,
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             id_vld,
    output logic             id_rdy,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_use,
    input  logic             id_rs2_use,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_write,
    output logic             ex_vld,
    input  logic             ex_rdy,
    input  logic             wb_vld,
    input  logic [4:0]       wb_rd,
    output logic             stall,
    output logic [CNT_W-1:0] inflight,
    output logic             err
`ifdef KRONOS_ISSUE_STATS_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    logic [31:0]      sb;
    logic [CNT_W-1:0] cnt;

    logic             wb_hit;
    logic             ret_vld;
    logic             spurious;
    logic             rd_trk;
    logic             hazard;
    logic             fire;
    logic             set_vld;
    logic [31:0]      ret_mask;
    logic [31:0]      sbe;
    logic [31:0]      set_mask;
    logic [31:0]      sb_nxt;
    logic [CNT_W-1:0] cnt_eff;
    logic [CNT_W-1:0] cnt_nxt;

    function automatic logic [31:0] onehot(input logic [4:0] idx);
        onehot = 32'd1 << idx;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A retire in this cycle frees its register for the instruction sitting in ID.
    always_comb begin
        wb_hit   = wb_vld && (wb_rd != 5'd0);
        ret_vld  = wb_hit && sb[wb_rd];
        spurious = wb_hit && !sb[wb_rd];
        ret_mask = ret_vld ? onehot(wb_rd) : 32'd0;
        sbe      = sb & ~ret_mask;
        cnt_eff  = cnt - CNT_W'(ret_vld);
        rd_trk   = id_rd_write && (id_rd != 5'd0);

        hazard = (id_rs1_use && sbe[id_rs1])
              || (id_rs2_use && sbe[id_rs2])
              || (rd_trk && sbe[id_rd])
              || (rd_trk && (cnt_eff == CNT_W'(MAX_INFLIGHT)));

        ex_vld = id_vld && !hazard && !flush && !rst;
        id_rdy = ex_rdy && !hazard && !flush && !rst;
        stall  = id_vld && hazard && !rst;
        fire   = id_vld && id_rdy;

        set_vld  = fire && rd_trk;
        set_mask = set_vld ? onehot(id_rd) : 32'd0;
        // OR-ing the set after the clear makes a same-index set win.
        sb_nxt   = (sbe | set_mask) & ~32'd1;

        case ({set_vld, ret_vld})
            2'b10:   cnt_nxt = cnt + CNT_W'(1);
            2'b01:   cnt_nxt = cnt - CNT_W'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb  <= 32'd0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            sb  <= sb_nxt;
            cnt <= cnt_nxt;
            if (spurious)
                err <= 1'b1;
        end
    end

    assign inflight = cnt;

`ifdef KRONOS_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= 32'd0;
        else if (stall)
            stall_cycles <= sat_inc32(stall_cycles);
    end
`else
    logic unused_sat;
    assign unused_sat = ^sat_inc32(32'd0);
`endif

endmodule

// File: doc/kronos_issue_sched.md
Name: kronos_issue_sched

Overview:
- Issue scheduler between the ID and EX stages of the Kronos pipeline.
- Gates the pipeIDEX_t valid/ready handshake using a register-write scoreboard. A decoded instruction issues to EX only when three things hold: none of its sources is pending, its destination is not pending, and the in-flight budget is not exhausted.
- Pending writes are cleared when writeback retires them.

Parameters:
- MAX_INFLIGHT, 2, maximum tracked register writes outstanding between issue and writeback retire (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; blocks issue this cycle.
- id_vld  in  1  ID has a decoded instruction.
- id_rdy  out  1  scheduler/EX accepts it.
- id_rs1  in  5  source register 1 index.
- id_rs2  in  5  source register 2 index.
- id_rs1_use  in  1  instruction reads rs1.
- id_rs2_use  in  1  instruction reads rs2.
- id_rd  in  5  destination register index.
- id_rd_write  in  1  instruction writes rd.
- ex_vld  out  1  pipe_in_vld to EX.
- ex_rdy  in  1  pipe_in_rdy from EX.
- wb_vld  in  1  writeback retires a register write this cycle.
- wb_rd  in  5  retired register index.
- stall  out  1  ID valid but held by a hazard.
- inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding tracked writes.
- err  out  1  sticky: retire of a register not pending.

Behaviour:
- State:
  - sb[31:0] scoreboard; sb[0] is hard-wired 0.
  - cnt inflight counter.
  - err sticky flag.
- Reset (rst=1 at a clk edge): sb=0, cnt=0, err=0.
  - Combinational outputs during reset: ex_vld=0, id_rdy=0, stall=0.
- Retire bypass: ret_mask = one-hot(wb_rd) when wb_vld && wb_rd!=0 && sb[wb_rd], else 0. Effective scoreboard sbe = sb & ~ret_mask.
- hazard is asserted on any of:
  - id_rs1_use && sbe[id_rs1]
  - id_rs2_use && sbe[id_rs2]
  - id_rd_write && id_rd!=0 && sbe[id_rd] (WAW)
  - id_rd_write && id_rd!=0 && cnt_eff==MAX_INFLIGHT, where cnt_eff = cnt − (ret_mask!=0)
- Handshake outputs:
  - ex_vld = id_vld && !hazard && !flush && !rst.
  - id_rdy = ex_rdy && !hazard && !flush && !rst.
  - fire = id_vld && id_rdy.
  - stall = id_vld && hazard && !rst.
  - Zero-latency combinational issue; no instruction buffering inside the block.
- Update at each clk edge when not in reset:
  - On fire with id_rd_write && id_rd!=0: set sb[id_rd].
  - On ret_mask!=0: clear that bit.
  - Same index set and cleared in one cycle: set wins; the bit stays 1.
  - Counter: cnt += set − clear, so simultaneous set and clear leaves cnt unchanged. cnt never exceeds MAX_INFLIGHT and never goes below 0.
- Spurious retire (wb_vld && wb_rd!=0 && !sb[wb_rd]): no state change except err←1. err stays set until reset.
- wb_vld with wb_rd==0 is ignored, with no error.
- Instructions with rd==0 or !id_rd_write are never tracked and are not limited by MAX_INFLIGHT.
- Flush:
  - Only blocks issue in the flush cycle.
  - Scoreboard entries already issued remain; the owning instructions still retire through WB.
  - Retires in a flush cycle are processed normally.
- Reset mid-operation clears all pending state. Late wb_vld for pre-reset instructions is treated as spurious and sets err.
- inflight = cnt (registered).

Optional Feature:
- Macro: KRONOS_ISSUE_STATS_EN.
- Defined:
  - Adds output port stall_cycles (out, 32): count of cycles with stall=1.
  - Saturates at 32'hFFFF_FFFF; cleared by rst.
  - Counts whether or not flush is asserted.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Independent issue: after reset, id_vld=1, rd=5, rd_write=1, ex_rdy=1 → ex_vld=1, id_rdy=1; next cycle sb[5]=1, inflight=1.
- RAW stall: x5 pending, next instr rs1=5, rs1_use=1 → stall=1, ex_vld=0. Then wb_vld=1, wb_rd=5 → same cycle ex_vld=1, id_rdy=1; sb[5] cleared and re-set only if that instr writes x5.
- Budget limit: MAX_INFLIGHT=2, issue writes to x1 and x2, then x3 → stall=1, inflight=2. Retire x1 → x3 issues that cycle; inflight stays 2.
- Writes to x0: three consecutive rd=0, rd_write=1 issues → no stall, inflight=0, sb all 0.
- Flush/backpressure/spurious retire: flush=1 with a clean instr → ex_vld=0, id_rdy=0, sb unchanged. ex_rdy=0 → ex_vld=1, id_rdy=0, no sb set. wb_vld=1, wb_rd=9 with x9 not pending → err=1 until rst.
- Stats (KRONOS_ISSUE_STATS_EN): hold a RAW hazard for 7 cycles → stall_cycles=7. rst → 0.
